// File: rtl/receive_packet_ddr.sv
// Receives one Ethernet frame at a time from the TSE Avalon-ST byte interface and packs it into
// 256-bit RAM words: payload at start_ram_addr+1.., then the byte-count header at start_ram_addr.
module receive_packet_ddr #(
    parameter int MAX_BYTES = 256
) (
    input  logic         clk_original,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [24:0]  start_ram_addr,
    input  logic [7:0]   ff_rx_data,
    input  logic         ff_rx_sop,
    input  logic         ff_rx_eop,
    input  logic         ff_rx_err,
    input  logic         ff_rx_dval,
    output logic         ff_rx_rdy,
    output logic [24:0]  ram_address,
    output logic [255:0] ram_data_write,
    output logic         ram_wren,
    input  logic         ram_ready,
    output logic         packet_done,
    output logic [10:0]  packet_size,
    output logic         drop_pulse,
    output logic [15:0]  pkt_count,
    output logic [15:0]  drop_count
);

    localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);

    typedef enum logic [2:0] {IDLE, RECV, WR_DATA, WR_HDR, DROP} state_t;

    state_t         state, state_nx;
    logic [24:0]    base_addr, base_nx;
    logic [5:0]     word_idx, widx_nx;
    logic [10:0]    byte_cnt, cnt_nx;
    logic [255:0]   word_buf, buf_nx;
    logic           eop_seen, eop_seen_nx;
    logic           rdy_nx, wren_nx, done_nx, drop_nx;
    logic [24:0]    addr_nx;
    logic [255:0]   data_nx;
    logic [10:0]    size_nx;
    logic [15:0]    pkt_nx, dcnt_nx;

    logic           accept, restart;
    logic [10:0]    cnt_cur, cnt_fill;
    logic [255:0]   buf_cur, buf_fill;
    logic [7:0]     lane_lo;

    always_ff @(posedge clk_original or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            base_addr      <= '0;
            word_idx       <= '0;
            byte_cnt       <= '0;
            word_buf       <= '0;
            eop_seen       <= 1'b0;
            ff_rx_rdy      <= 1'b0;
            ram_wren       <= 1'b0;
            ram_address    <= '0;
            ram_data_write <= '0;
            packet_done    <= 1'b0;
            drop_pulse     <= 1'b0;
            packet_size    <= '0;
            pkt_count      <= '0;
            drop_count     <= '0;
        end else begin
            state          <= state_nx;
            base_addr      <= base_nx;
            word_idx       <= widx_nx;
            byte_cnt       <= cnt_nx;
            word_buf       <= buf_nx;
            eop_seen       <= eop_seen_nx;
            ff_rx_rdy      <= rdy_nx;
            ram_wren       <= wren_nx;
            ram_address    <= addr_nx;
            ram_data_write <= data_nx;
            packet_done    <= done_nx;
            drop_pulse     <= drop_nx;
            packet_size    <= size_nx;
            pkt_count      <= pkt_nx;
            drop_count     <= dcnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        base_nx     = base_addr;
        widx_nx     = word_idx;
        cnt_nx      = byte_cnt;
        buf_nx      = word_buf;
        eop_seen_nx = eop_seen;
        addr_nx     = ram_address;
        data_nx     = ram_data_write;
        done_nx     = 1'b0;
        drop_nx     = 1'b0;
        size_nx     = packet_size;
        pkt_nx      = pkt_count;
        dcnt_nx     = drop_count;

        accept  = ff_rx_dval && ff_rx_rdy;
        restart = accept && ff_rx_sop && (state == IDLE || state == RECV);
        // A restarting byte lands at position 0 of an empty word regardless of what was buffered.
        cnt_cur = restart ? '0 : byte_cnt;
        buf_cur = restart ? '0 : word_buf;
        lane_lo = {cnt_cur[4:2], ~cnt_cur[1:0], 3'b000};
        buf_fill = buf_cur;
        buf_fill[lane_lo +: 8] = ff_rx_data;
        cnt_fill = cnt_cur + 11'd1;

        case (state)
            IDLE, RECV: begin
                if (restart && state == RECV) begin
                    drop_nx = 1'b1;
                    dcnt_nx = drop_count + 16'd1;
                end
                if (restart || (accept && state == RECV)) begin
                    if (!restart && byte_cnt == MAX_CNT) begin
                        drop_nx = ff_rx_eop;
                        dcnt_nx = ff_rx_eop ? drop_count + 16'd1 : drop_count;
                        state_nx = ff_rx_eop ? IDLE : DROP;
                    end else begin
                        cnt_nx = cnt_fill;
                        buf_nx = buf_fill;
                        if (restart) begin
                            base_nx = start_ram_addr;
                            widx_nx = '0;
                        end
                        if (ff_rx_eop && ff_rx_err) begin
                            drop_nx  = 1'b1;
                            dcnt_nx  = drop_count + 16'd1;
                            state_nx = IDLE;
                        end else if (ff_rx_eop || cnt_fill[4:0] == 5'd0) begin
                            state_nx    = WR_DATA;
                            eop_seen_nx = ff_rx_eop;
                            addr_nx     = base_nx + 25'd1 + 25'(widx_nx);
                            data_nx     = buf_fill;
                        end else begin
                            state_nx = RECV;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (ram_ready) begin
                    buf_nx  = '0;
                    widx_nx = word_idx + 6'd1;
                    if (eop_seen) begin
                        state_nx = WR_HDR;
                        addr_nx  = base_addr;
                        data_nx  = {245'd0, byte_cnt};
                    end else begin
                        state_nx = RECV;
                    end
                end
            end
            WR_HDR: begin
                if (ram_ready) begin
                    done_nx  = 1'b1;
                    size_nx  = byte_cnt;
                    pkt_nx   = pkt_count + 16'd1;
                    state_nx = IDLE;
                end
            end
            DROP: begin
                if (accept && ff_rx_eop) begin
                    drop_nx  = 1'b1;
                    dcnt_nx  = drop_count + 16'd1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        rdy_nx  = (state_nx == IDLE) ? enable : (state_nx == RECV || state_nx == DROP);
        wren_nx = (state_nx == WR_DATA || state_nx == WR_HDR);
    end

endmodule
